// File: rtl/crc8_frame_checker.sv
// crc8_frame_checker: receive-side CRC-8/EBU frame checker.
// Payload bytes are forwarded with the trailing CRC byte stripped; one byte is
// held back so the final payload byte can be tagged with axiol. At end of frame
// the check result and payload length are reported and saturating good/bad
// frame counters are updated.
module crc8_frame_checker #(
  parameter int LEN_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             axiiv,
  input  logic [7:0]       axiid,
  input  logic             axiil,
  output logic             axiov,
  output logic [7:0]       axiod,
  output logic             axiol,
  output logic             done,
  output logic             crc_ok,
  output logic [LEN_W-1:0] len,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } state_t;

  localparam logic [7:0] CRC_INIT = 8'hFF;
  localparam logic [7:0] CRC_POLY_REFL = 8'hB8;

  // Reflected CRC-8/EBU update of one byte (poly 0x1D, LSB first).
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in,
                                           input logic [7:0] data);
    logic [7:0] c;
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

  // Saturating increment of the payload length counter.
  function automatic logic [LEN_W-1:0] sat_inc_len(input logic [LEN_W-1:0] v);
    return (&v) ? v : v + {{(LEN_W-1){1'b0}}, 1'b1};
  endfunction

  // Saturating increment of a frame counter.
  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  state_t           state_q, state_d;
  logic [7:0]       crc_q, crc_d;
  logic [7:0]       held_q, held_d;
  logic [LEN_W-1:0] len_cnt_q, len_cnt_d;
  logic             axiov_q, axiov_d;
  logic [7:0]       axiod_q, axiod_d;
  logic             axiol_q, axiol_d;
  logic             done_q, done_d;
  logic             crc_ok_q, crc_ok_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] bad_q, bad_d;

  // Next-state and registered-output logic for the hold-back FSM and CRC.
  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    held_d    = held_q;
    len_cnt_d = len_cnt_q;
    axiov_d   = 1'b0;
    axiod_d   = axiod_q;
    axiol_d   = 1'b0;
    done_d    = 1'b0;
    crc_ok_d  = crc_ok_q;
    len_d     = len_q;
    good_d    = good_q;
    bad_d     = bad_q;

    if (axiiv) begin
      if (!axiil) begin
        // Payload byte: fold into CRC, push previously held byte out.
        crc_d     = crc8_byte(crc_q, axiid);
        len_cnt_d = sat_inc_len(len_cnt_q);
        held_d    = axiid;
        if (state_q == HELD) begin
          axiov_d = 1'b1;
          axiod_d = held_q;
        end
        state_d = HELD;
      end else begin
        // CRC byte: flush held byte as last, report, and rearm for next frame.
        if (state_q == HELD) begin
          axiov_d = 1'b1;
          axiol_d = 1'b1;
          axiod_d = held_q;
        end
        done_d   = 1'b1;
        crc_ok_d = (axiid == crc_q);
        len_d    = len_cnt_q;
        if (axiid == crc_q) begin
          good_d = sat_inc_cnt(good_q);
        end else begin
          bad_d = sat_inc_cnt(bad_q);
        end
        crc_d     = CRC_INIT;
        len_cnt_d = '0;
        state_d   = EMPTY;
      end
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= EMPTY;
      crc_q     <= CRC_INIT;
      len_cnt_q <= '0;
      axiov_q   <= 1'b0;
      axiod_q   <= 8'h00;
      axiol_q   <= 1'b0;
      done_q    <= 1'b0;
      crc_ok_q  <= 1'b0;
      len_q     <= '0;
      good_q    <= '0;
      bad_q     <= '0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      len_cnt_q <= len_cnt_d;
      axiov_q   <= axiov_d;
      axiod_q   <= axiod_d;
      axiol_q   <= axiol_d;
      done_q    <= done_d;
      crc_ok_q  <= crc_ok_d;
      len_q     <= len_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
    end
  end

  // Hold-back data byte; only meaningful while in HELD, so it needs no reset.
  always_ff @(posedge clk) begin
    held_q <= held_d;
  end

  assign axiov    = axiov_q;
  assign axiod    = axiod_q;
  assign axiol    = axiol_q;
  assign done     = done_q;
  assign crc_ok   = crc_ok_q;
  assign len      = len_q;
  assign good_cnt = good_q;
  assign bad_cnt  = bad_q;

endmodule
